// File: rtl/datapath_ctrl.sv
// Moore FSM controller for the x/y datapath. It computes x = a*b mod 2^WIDTH by
// repeated addition and pulses done when the result is ready.
module datapath_ctrl #(
    parameter int         WIDTH   = 4,
    parameter logic [1:0] OP_PASS = 2'b00,
    parameter logic [1:0] OP_ADD  = 2'b01,
    parameter logic [1:0] OP_DEC  = 2'b10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             zero,
    output logic [WIDTH-1:0] imm,
    output logic [1:0]       op_sel,
    output logic             en_x,
    output logic             en_y,
    output logic             y_sel,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_B  = 3'd1,
        CLEAR_X = 3'd2,
        TEST    = 3'd3,
        ADD     = 3'd4,
        DEC     = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    // Operands are latched only on an accepted start, so input changes mid-run are harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                a_r <= a;
                b_r <= b;
            end
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = start ? LOAD_B : IDLE;
            LOAD_B:  state_d = CLEAR_X;
            CLEAR_X: state_d = TEST;
            TEST:    state_d = zero ? DONE : ADD;
            ADD:     state_d = DEC;
            DEC:     state_d = TEST;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only the registered state and operands; no input reaches them combinationally.
    always_comb begin
        imm    = '0;
        op_sel = OP_PASS;
        en_x   = 1'b0;
        en_y   = 1'b0;
        y_sel  = 1'b0;
        done   = 1'b0;
        case (state_q)
            LOAD_B: begin
                imm   = b_r;
                y_sel = 1'b1;
                en_y  = 1'b1;
            end
            CLEAR_X: begin
                op_sel = OP_PASS;
                en_x   = 1'b1;
            end
            ADD: begin
                op_sel = OP_ADD;
                imm    = a_r;
                en_x   = 1'b1;
            end
            DEC: begin
                op_sel = OP_DEC;
                en_y   = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign state_out = state_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl driving a behavioural x/y datapath.
module tb_datapath_ctrl;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             zero;
    logic [WIDTH-1:0] imm;
    logic [1:0]       op_sel;
    logic             en_x;
    logic             en_y;
    logic             y_sel;
    logic             busy;
    logic             done;
    logic [2:0]       state_out;

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] alu;

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int saw_loop = 0;

    always #5 clk = ~clk;

    datapath_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .zero      (zero),
        .imm       (imm),
        .op_sel    (op_sel),
        .en_x      (en_x),
        .en_y      (en_y),
        .y_sel     (y_sel),
        .busy      (busy),
        .done      (done),
        .state_out (state_out)
    );

    // Behavioural datapath the controller is meant to sequence.
    always_comb begin
        alu = imm;
        case (op_sel)
            2'b01:   alu = x + imm;
            2'b10:   alu = y - 1'b1;
            default: alu = imm;
        endcase
    end

    assign zero = (y == '0);

    always_ff @(posedge clk) begin
        if (en_x) x <= alu;
        if (en_y) y <= y_sel ? imm : alu;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
        if (state_out == 3'd4 || state_out == 3'd5) saw_loop = 1;
        if (en_x === 1'b1 && en_y === 1'b1) chk("en_x_en_y_exclusive", 1, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"}, state_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_imm"}, imm, 0);
        chk({tag, "_op_sel"}, op_sel, 0);
        chk({tag, "_enables"}, {en_x, en_y, y_sel}, 0);
    endtask

    // Drive one accepted start; returns with the bench observing cycle 1 (LOAD_B).
    task automatic start_run(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic hold);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_state(input logic [2:0] st, output int n);
        n = 0;
        while (state_out !== st && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int n2;
        int d0;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk_idle("reset");
        rst_n = 1'b1;
        tick();
        chk_idle("idle_after_reset");

        // a=3, b=5: 15 after 19 cycles
        start_run(4'd3, 4'd5, 1'b0);
        chk("load_b_state", state_out, 1);
        chk("load_b_ctrl", {imm, y_sel, en_y, en_x, busy}, {4'd5, 1'b1, 1'b1, 1'b0, 1'b1});
        tick();
        chk("clear_x_state", state_out, 2);
        chk("clear_x_ctrl", {imm, op_sel, en_x, en_y}, {4'd0, 2'b00, 1'b1, 1'b0});
        tick();
        chk("test_ctrl", {state_out, en_x, en_y}, {3'd3, 1'b0, 1'b0});
        wait_state(3'd4, n);
        chk("add_ctrl", {imm, op_sel, en_x, en_y}, {4'd3, 2'b01, 1'b1, 1'b0});
        tick();
        chk("dec_ctrl", {state_out, op_sel, y_sel, en_y, en_x}, {3'd5, 2'b10, 1'b0, 1'b1, 1'b0});
        wait_done(n);
        chk("3x5_cycles", 5 + n, 19);
        chk("3x5_x", x, 15);
        chk("3x5_y", y, 0);
        chk("3x5_done_state", state_out, 6);
        chk("3x5_done_busy", busy, 1);
        tick();
        chk_idle("3x5_after");

        // a=9, b=0: loop skipped
        saw_loop = 0;
        start_run(4'd9, 4'd0, 1'b0);
        wait_done(n);
        chk("9x0_cycles", 1 + n, 4);
        chk("9x0_x", x, 0);
        chk("9x0_no_loop", saw_loop, 0);
        tick();

        // a=7, b=3: 21 mod 16
        start_run(4'd7, 4'd3, 1'b0);
        wait_done(n);
        chk("7x3_cycles", 1 + n, 13);
        chk("7x3_x", x, 5);
        tick();

        // start pulsed during ADD with new operands is ignored
        d0 = done_cnt;
        start_run(4'd5, 4'd2, 1'b0);
        wait_state(3'd4, n);
        a     = 4'd1;
        b     = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n2);
        chk("busy_start_cycles", 1 + n + 1 + n2, 10);
        chk("busy_start_x", x, 10);
        tick();
        tick();
        tick();
        chk("busy_start_one_done", done_cnt - d0, 1);
        chk("busy_start_idle", state_out, 0);

        // reset asserted during DEC aborts the run
        d0 = done_cnt;
        start_run(4'd2, 4'd4, 1'b0);
        wait_state(3'd5, n);
        chk("pre_reset_dec", state_out, 5);
        rst_n = 1'b0;
        tick();
        chk_idle("mid_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("mid_reset_no_done", done_cnt - d0, 0);
        chk("mid_reset_stays_idle", state_out, 0);

        // start held high: back-to-back runs every 11 cycles
        start_run(4'd1, 4'd2, 1'b1);
        wait_done(n);
        chk("held_first_cycles", 1 + n, 10);
        chk("held_first_x", x, 2);
        tick();
        wait_done(n);
        chk("held_period_1", 1 + n, 11);
        chk("held_x_1", x, 2);
        tick();
        wait_done(n);
        start = 1'b0;
        chk("held_period_2", 1 + n, 11);
        chk("held_x_2", x, 2);
        tick();
        tick();
        chk_idle("held_release");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
